// File: rtl/rv_muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// funct3 encodings, decode constants, FSM state type and signedness helpers.
package rv_muldiv_pkg;

  // M-extension funct3 encodings
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  // Decode constants used by ID to qualify 'start'
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } md_state_e;

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM
  function automatic logic op_a_signed(input logic [2:0] f3);
    logic sgn;
    case (f3)
      MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM: sgn = 1'b1;
      default:                                   sgn = 1'b0;
    endcase
    return sgn;
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV and REM
  function automatic logic op_b_signed(input logic [2:0] f3);
    logic sgn;
    case (f3)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: sgn = 1'b1;
      default:                         sgn = 1'b0;
    endcase
    return sgn;
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative RV32M multiply/divide unit.
// Radix-2: 32 shift-add / restoring-divide iterations on operand magnitudes,
// followed by one sign-fix cycle. Divide-by-zero and signed overflow are
// resolved in the start cycle without stalling the pipeline.
module ex_muldiv_unit
  import rv_muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  input  logic [4:0]        rd_in,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [4:0]        rd_out
);

  // Registered state
  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*XLEN-1:0]  acc_q, acc_d;      // product, or {remainder, quotient}
  logic [XLEN-1:0]    opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [2:0]         f3_q, f3_d;
  logic [4:0]         rd_q, rd_d;
  logic               neg_res_q, neg_res_d;  // negate product / quotient
  logic               neg_rem_q, neg_rem_d;  // negate remainder
  logic               done_q, done_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic [4:0]         rd_out_q, rd_out_d;

  // Start-cycle operand decode
  logic               a_neg_s, b_neg_s;
  logic [XLEN-1:0]    a_mag_s, b_mag_s;
  logic               is_div_s, div_zero_s, ovf_s, fast_s;
  logic [XLEN-1:0]    fast_res_s;

  // Iteration datapath
  logic [XLEN:0]      mul_sum_s;
  logic [2*XLEN-1:0]  mul_next_s;
  logic [XLEN:0]      div_sh_s, div_diff_s;
  logic [2*XLEN-1:0]  div_next_s;

  // Sign fix datapath
  logic [2*XLEN-1:0]  prod_fix_s;
  logic [XLEN-1:0]    quot_fix_s, rem_fix_s, fix_res_s;

  assign a_neg_s = op_a_signed(funct3) & op_a[XLEN-1];
  assign b_neg_s = op_b_signed(funct3) & op_b[XLEN-1];
  assign a_mag_s = a_neg_s ? (~op_a + XLEN'(1)) : op_a;
  assign b_mag_s = b_neg_s ? (~op_b + XLEN'(1)) : op_b;

  assign is_div_s   = funct3[2];
  assign div_zero_s = (op_b == {XLEN{1'b0}});
  assign ovf_s      = ((funct3 == MD_DIV) || (funct3 == MD_REM)) &&
                      (op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (op_b == {XLEN{1'b1}});
  assign fast_s     = is_div_s & (div_zero_s | ovf_s);

  // Fast-path result: funct3[1] selects remainder over quotient
  always_comb begin
    fast_res_s = {XLEN{1'b0}};
    if (div_zero_s) begin
      fast_res_s = funct3[1] ? op_a : {XLEN{1'b1}};
    end else begin
      fast_res_s = funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // One shift-add step: add multiplicand when the low multiplier bit is set,
  // then shift the whole 64-bit accumulator right including the carry.
  assign mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                      (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
  assign mul_next_s = {mul_sum_s, acc_q[XLEN-1:1]};

  // One restoring-divide step: shift in the next dividend bit, trial-subtract
  assign div_sh_s   = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff_s = div_sh_s - {1'b0, opnd_q};

  // Keep the difference when the trial subtraction did not borrow
  always_comb begin
    div_next_s = {2*XLEN{1'b0}};
    if (!div_diff_s[XLEN]) begin
      div_next_s = {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_next_s = {div_sh_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  assign prod_fix_s = neg_res_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;
  assign quot_fix_s = neg_res_q ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
  assign rem_fix_s  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + XLEN'(1))
                                : acc_q[2*XLEN-1:XLEN];

  // Select the architectural result from the sign-corrected datapath
  always_comb begin
    case (f3_q)
      MD_MUL:                       fix_res_s = prod_fix_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fix_res_s = quot_fix_s;
      MD_REM, MD_REMU:              fix_res_s = rem_fix_s;
      default:                      fix_res_s = {XLEN{1'b0}};
    endcase
  end

  // Stall request is combinational so it covers the start cycle itself
  assign busy = ~reset & ((state_q == CALC) || (state_q == FIX) ||
                          (((state_q == IDLE) || (state_q == DONE)) & start & ~fast_s));

  // Next-state logic; flush wins over every state and over a same-cycle start
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            f3_d = funct3;
            rd_d = rd_in;
            if (fast_s) begin
              state_d  = DONE;
              done_d   = 1'b1;
              result_d = fast_res_s;
              rd_out_d = rd_in;
            end else begin
              state_d   = CALC;
              cnt_d     = {CNT_W{1'b0}};
              neg_res_d = a_neg_s ^ b_neg_s;
              neg_rem_d = is_div_s & a_neg_s;
              if (is_div_s) begin
                acc_d  = {{XLEN{1'b0}}, a_mag_s};
                opnd_d = b_mag_s;
              end else begin
                acc_d  = {{XLEN{1'b0}}, b_mag_s};
                opnd_d = a_mag_s;
              end
            end
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
          acc_d = f3_q[2] ? div_next_s : mul_next_s;
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        FIX: begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = fix_res_s;
          rd_out_d = rd_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      acc_q     <= {2*XLEN{1'b0}};
      opnd_q    <= {XLEN{1'b0}};
      f3_q      <= 3'b000;
      rd_q      <= 5'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= {XLEN{1'b0}};
      rd_out_q  <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ex_muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  // Present one op (called #1 after a rising edge), drop start after the
  // sampling edge, and wait (bounded) for done. edges counts rising edges
  // from the sampling edge (=1) to the first edge after which done is high.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        output int edges, output int busy_cycles,
                        output bit got_done);
    funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    edges = 0; busy_cycles = 0; got_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (busy) busy_cycles++;
      @(posedge clk);
      edges++;
      #1;
      if (edges == 1) start = 1'b0;
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; start = 1'b1;
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4; rd_in = 5'd1;
    @(posedge clk); #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    total_cnt++;
    if (result !== 32'h0) $display("FAIL reset_result: got %h want 0", result); else pass_cnt++;
    total_cnt++;
    if (rd_out !== 5'd0) $display("FAIL reset_rd_out: got %0d want 0", rd_out); else pass_cnt++;
    start = 1'b0;
    reset = 1'b0;
    idle_cycle();
  endtask

  task automatic test_mul_latency();
    int e, bc; bit gd;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, e, bc, gd);
    total_cnt++;
    if (gd !== 1'b1) $display("FAIL mul_done_seen: got %b want 1", gd); else pass_cnt++;
    total_cnt++;
    if (e != 34) $display("FAIL mul_latency: got %0d edges want 34", e); else pass_cnt++;
    total_cnt++;
    if (bc != 34) $display("FAIL mul_busy_cycles: got %0d want 34", bc); else pass_cnt++;
    total_cnt++;
    if (result !== 32'hFFFF_FFEB) $display("FAIL mul_result: got %h want ffffffeb", result); else pass_cnt++;
    total_cnt++;
    if (rd_out !== 5'd5) $display("FAIL mul_rd_out: got %0d want 5", rd_out); else pass_cnt++;
    idle_cycle();
    total_cnt++;
    if (done !== 1'b0) $display("FAIL mul_done_pulse: got %b want 0", done); else pass_cnt++;
    total_cnt++;
    if (result !== 32'hFFFF_FFEB) $display("FAIL mul_result_hold: got %h want ffffffeb", result); else pass_cnt++;
  endtask

  task automatic test_mulh();
    logic [2:0]  f3s [3] = '{3'b011, 3'b001, 3'b010};
    logic [31:0] exps[3] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
    int e, bc; bit gd;
    for (int i = 0; i < 3; i++) begin
      run_op(f3s[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'(10 + i), e, bc, gd);
      total_cnt++;
      if (!gd || result !== exps[i])
        $display("FAIL mulh_%0d: got %h done=%b want %h", i, result, gd, exps[i]);
      else pass_cnt++;
      idle_cycle();
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3s [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exps[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0000_000E, 32'h0000_0002};
    int e, bc; bit gd;
    for (int i = 0; i < 4; i++) begin
      run_op(f3s[i], as[i], bs[i], 5'(20 + i), e, bc, gd);
      total_cnt++;
      if (!gd || result !== exps[i])
        $display("FAIL div_%0d: got %h done=%b want %h", i, result, gd, exps[i]);
      else pass_cnt++;
      total_cnt++;
      if (rd_out !== 5'(20 + i)) $display("FAIL div_rd_%0d: got %0d want %0d", i, rd_out, 20 + i);
      else pass_cnt++;
      idle_cycle();
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  f3s [4] = '{3'b100, 3'b110, 3'b100, 3'b110};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0000_0000};
    int e, bc; bit gd;
    for (int i = 0; i < 4; i++) begin
      run_op(f3s[i], as[i], bs[i], 5'(2 + i), e, bc, gd);
      total_cnt++;
      if (!gd || result !== exps[i])
        $display("FAIL fast_res_%0d: got %h done=%b want %h", i, result, gd, exps[i]);
      else pass_cnt++;
      total_cnt++;
      if (e != 1) $display("FAIL fast_latency_%0d: got %0d edges want 1", i, e); else pass_cnt++;
      total_cnt++;
      if (bc != 0) $display("FAIL fast_busy_%0d: got %0d busy cycles want 0", i, bc); else pass_cnt++;
      idle_cycle();
    end
  endtask

  task automatic test_back_to_back();
    int e, bc; bit gd;
    run_op(3'b101, 32'd100, 32'd7, 5'd3, e, bc, gd);
    total_cnt++;
    if (!gd || result !== 32'd14) $display("FAIL b2b_first: got %h want 0000000e", result); else pass_cnt++;
    run_op(3'b111, 32'd100, 32'd7, 5'd8, e, bc, gd);
    total_cnt++;
    if (e != 34 || bc != 34) $display("FAIL b2b_timing: got %0d edges %0d busy want 34/34", e, bc); else pass_cnt++;
    total_cnt++;
    if (!gd || result !== 32'd2 || rd_out !== 5'd8)
      $display("FAIL b2b_second: got %h rd %0d want 00000002 rd 8", result, rd_out);
    else pass_cnt++;
    run_op(3'b101, 32'd1, 32'd0, 5'd9, e, bc, gd);
    total_cnt++;
    if (!gd || e != 1 || result !== 32'hFFFF_FFFF)
      $display("FAIL b2b_fast: got %h edges %0d want ffffffff in 1", result, e);
    else pass_cnt++;
    idle_cycle();
  endtask

  task automatic test_flush();
    int e, bc, done_seen; bit gd;
    run_op(3'b101, 32'd100, 32'd7, 5'd6, e, bc, gd);
    total_cnt++;
    if (!gd || result !== 32'd14) $display("FAIL flush_pre: got %h want 0000000e", result); else pass_cnt++;
    idle_cycle();
    funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; start = 1'b1;
    funct3 = 3'b101; op_a = 32'd50; op_b = 32'd5; rd_in = 5'd9;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL flush_done: got %b want 0", done); else pass_cnt++;
    total_cnt++;
    if (result !== 32'd14 || rd_out !== 5'd6)
      $display("FAIL flush_hold: got %h rd %0d want 0000000e rd 6", result, rd_out);
    else pass_cnt++;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    total_cnt++;
    if (done_seen != 0) $display("FAIL flush_start_dropped: got %0d active cycles want 0", done_seen); else pass_cnt++;
    run_op(3'b101, 32'd9, 32'd3, 5'd11, e, bc, gd);
    total_cnt++;
    if (!gd || result !== 32'd3 || rd_out !== 5'd11)
      $display("FAIL flush_after: got %h rd %0d want 00000003 rd 11", result, rd_out);
    else pass_cnt++;
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    int e; bit gd;
    funct3 = 3'b000; op_a = 32'd7; op_b = 32'd3; rd_in = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (done !== 1'b0 || result !== 32'h0 || rd_out !== 5'd0)
      $display("FAIL rst_mid_outputs: got done %b result %h rd %0d want 0 0 0", done, result, rd_out);
    else pass_cnt++;
    reset = 1'b0;
    idle_cycle();
    // Start held through early CALC with different operands must not restart
    funct3 = 3'b011; op_a = 32'h0001_0000; op_b = 32'h0003_0000; rd_in = 5'd12; start = 1'b1;
    @(posedge clk); #1;
    e = 1;
    op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; funct3 = 3'b000; rd_in = 5'd13;
    gd = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 5) start = 1'b0;
      @(posedge clk); #1;
      e++;
      if (done) begin
        gd = 1'b1;
        break;
      end
    end
    total_cnt++;
    if (!gd || e != 34) $display("FAIL held_start_timing: got %0d edges done=%b want 34", e, gd); else pass_cnt++;
    total_cnt++;
    if (result !== 32'h0000_0003 || rd_out !== 5'd12)
      $display("FAIL held_start_result: got %h rd %0d want 00000003 rd 12", result, rd_out);
    else pass_cnt++;
    idle_cycle();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; start = 1'b0;
    funct3 = 3'b000; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
    test_reset();
    test_mul_latency();
    test_mulh();
    test_div();
    test_fast_path();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
